state_mem_ctrl: RTL and testbench

- Owns one port of the 2-bit x 16384 pixel-state dual-port RAM.
- Shares that port between two requesters (port 0: waveform update pipeline, port 1: host/debug access) with round-robin arbitration.
- Contains a built-in bulk-clear engine that fills the whole RAM with a programmable 2-bit value.
- Sits between the requesters and the RAM port; the other RAM port is untouched.

---
 rtl/state_mem_ctrl_pkg.sv | 18 +
 rtl/state_mem_ctrl_arb.sv | 26 ++
 rtl/state_mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_state_mem_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/state_mem_ctrl_pkg.sv
// Shared constants for the pixel-state RAM controller: FSM encoding,
// default geometry and the pixel-state values used as clear fills.
package state_mem_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } st_e;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 2;

    localparam logic [1:0] PX_BLANK = 2'b00;
    localparam logic [1:0] PX_LOW   = 2'b01;
    localparam logic [1:0] PX_HIGH  = 2'b10;
    localparam logic [1:0] PX_FULL  = 2'b11;

endpackage

// File: rtl/state_mem_ctrl_arb.sv
// rr_arb2: two-input round-robin arbiter with a one-hot combinational grant.
// The pointer only moves when both inputs compete for the same cycle.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req) gnt = ptr ? 2'b10 : 2'b01;
            else      gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ptr <= 1'b0;
        else if (en && &req) ptr <= ~ptr;
    end

endmodule

// File: rtl/state_mem_ctrl.sv
// Arbitrates one port of the pixel-state RAM between two requesters and runs a
// bulk-clear engine. STATE_MEM_CLEAR_ON_RESET_EN: auto-clear to 0 after reset.
module state_mem_ctrl
    import state_mem_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_value,
    output logic          clear_busy,
    output logic          clear_done,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

`ifdef STATE_MEM_CLEAR_ON_RESET_EN
    localparam logic BOOT_CLR = 1'b1;
`else
    localparam logic BOOT_CLR = 1'b0;
`endif

    st_e           st;
    logic          boot;
    logic [AW-1:0] cnt;
    logic [DW-1:0] cval;
    logic [1:0]    gnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] hold0, hold1;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (st == ST_IDLE && !boot),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Idle cycles replay the last address/data so the RAM pins stay quiet.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_din  = din_q;
        if (st == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = cnt;
            mem_din  = cval;
        end else if (gnt[0]) begin
            mem_we   = req0_we;
            mem_addr = req0_addr;
            mem_din  = req0_wdata;
        end else if (gnt[1]) begin
            mem_we   = req1_we;
            mem_addr = req1_addr;
            mem_din  = req1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= mem_addr;
            din_q  <= mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            boot       <= BOOT_CLR;
            cnt        <= '0;
            cval       <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (boot) begin
                        st         <= ST_CLEAR;
                        cval       <= '0;
                        clear_busy <= 1'b1;
                        boot       <= 1'b0;
                    end else if (clear_start) begin
                        st         <= ST_CLEAR;
                        cval       <= clear_value;
                        clear_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        st         <= ST_IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // RAM output is already registered; the response valid just trails the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            hold0      <= '0;
            hold1      <= '0;
        end else begin
            rsp0_valid <= gnt[0] & ~req0_we;
            rsp1_valid <= gnt[1] & ~req1_we;
            if (rsp0_valid) hold0 <= mem_dout;
            if (rsp1_valid) hold1 <= mem_dout;
        end
    end

    assign rsp0_data = rsp0_valid ? mem_dout : hold0;
    assign rsp1_data = rsp1_valid ? mem_dout : hold1;

endmodule

// File: tb/tb_state_mem_ctrl.sv
// Scoreboard bench for state_mem_ctrl with a behavioural registered-read RAM.
module tb_state_mem_ctrl;

    localparam int AW    = 14;
    localparam int DW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk, rst_n;
    logic          clear_start, clear_busy, clear_done;
    logic [DW-1:0] clear_value;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] q0[$], q1[$];
    int total = 0, bad = 0, n0 = 0, n1 = 0;

    state_mem_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rsp0_valid) begin
            n0++;
            if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
            else                chk("rsp0_data", int'(rsp0_data), int'(q0.pop_front()));
        end
        if (rst_n && rsp1_valid) begin
            n1++;
            if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
            else                chk("rsp1_data", int'(rsp1_data), int'(q1.pop_front()));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic req(input int p, input bit we, input int addr, input int wd, input int ex);
        int  k = 0;
        bit  g = 0;
        logic [AW-1:0] a;
        logic [DW-1:0] d, e;
        a = addr[AW-1:0];
        d = wd[DW-1:0];
        e = ex[DW-1:0];
        if (p == 0) begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
        else        begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
        while (!g && k < 50) begin
            @(negedge clk);
            g = (p == 0) ? req0_ready : req1_ready;
            k++;
        end
        chk("grant_wait", int'(g), 1);
        if (g && !we) begin
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk); #1;
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
    endtask

    task automatic wait_init();
`ifdef STATE_MEM_CLEAR_ON_RESET_EN
        int k = 0;
        bit d = 0;
        @(posedge clk); #1;
        chk("boot_busy", int'(clear_busy), 1);
        while (!d && k < 20000) begin
            @(negedge clk);
            d = clear_done;
            k++;
        end
        chk("boot_done", int'(d), 1);
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        int nb, nd, rv, k, b0, b1;
        rst_n = 0; clear_start = 0; clear_value = 0;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(clear_busy), 0);
        chk("rst_done", int'(clear_done), 0);
        chk("rst_rsp0_valid", int'(rsp0_valid), 0);
        chk("rst_rsp1_valid", int'(rsp1_valid), 0);
        chk("rst_rsp0_data", int'(rsp0_data), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        @(posedge clk); #1;
        rst_n = 1;
        wait_init();
`ifdef STATE_MEM_CLEAR_ON_RESET_EN
        req(0, 0, 'h1234, 0, 0);
        req(1, 0, 'h3FFF, 0, 0);
        drain();
`endif

        // write then read-back on port 0, latency 1
        req(0, 1, 'h0005, 2, 0);
        req(0, 0, 'h0005, 0, 2);
        chk("rsp0_latency", int'(rsp0_valid), 1);
        drain();

        // contended reads alternate starting at port 0
        req(0, 1, 'h0010, 1, 0);
        req(1, 1, 'h0020, 3, 0);
        b0 = n0; b1 = n1;
        req0_valid = 1; req0_we = 0; req0_addr = 'h0010;
        req1_valid = 1; req1_we = 0; req1_addr = 'h0020;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("one_hot_grant", int'(req0_ready) + int'(req1_ready), 1);
            chk("rr_order", int'(req1_ready), c % 2);
            if (req0_ready) q0.push_back(2'b01);
            if (req1_ready) q1.push_back(2'b11);
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        drain();
        chk("rr_cnt0", n0 - b0, 3);
        chk("rr_cnt1", n1 - b1, 3);

        // bulk clear to 11 with port 0 stalled throughout; mid-clear start ignored
        clear_start = 1; clear_value = 2'b11;
        @(negedge clk);
        chk("busy_start_cycle", int'(clear_busy), 0);
        @(posedge clk); #1;
        clear_start = 0;
        req0_valid = 1; req0_we = 0; req0_addr = 'h2000;
        nb = 0; nd = 0; rv = 0; k = 0;
        while (k < 20000) begin
            @(negedge clk);
            k++;
            if (clear_done) nd++;
            if (clear_busy) begin
                nb++;
                if (req0_ready) rv++;
                clear_start = (nb == 50);
            end else if (nb > 0) begin
                break;
            end
        end
        clear_start = 0;
        chk("clear_busy_len", nb, DEPTH);
        chk("stall_ready", rv, 0);
        chk("done_with_busy_drop", int'(clear_done), 1);
        chk("first_idle_grant", int'(req0_ready), 1);
        if (req0_ready) q0.push_back(2'b11);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        chk("done_one_pulse", nd + int'(clear_done), 1);
        @(posedge clk); #1;
        req(1, 0, 'h0000, 0, 3);
        req(0, 0, 'h3FFF, 0, 3);
        req(1, 0, 'h0005, 0, 3);
        drain();

        // reset in the middle of a clear
        clear_start = 1; clear_value = 2'b01;
        @(posedge clk); #1;
        clear_start = 0;
        repeat (100) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("midrst_busy", int'(clear_busy), 0);
        chk("midrst_done", int'(clear_done), 0);
        chk("midrst_mem_we", int'(mem_we), 0);
        chk("midrst_rsp_valid", int'(rsp0_valid) + int'(rsp1_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        wait_init();
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (clear_done) nd++;
        end
        chk("no_done_after_abort", nd, 0);
        @(posedge clk); #1;
        req(1, 1, 'h0007, 2, 0);
        req(1, 0, 'h0007, 0, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
